piso_shift_tx: RTL and testbench

Parallel-in/serial-out transmitter for the shift-register family. It accepts an N-bit word over a valid/ready handshake and shifts it out one bit per enabled cycle, either MSB-first or LSB-first. It pulses `done` after the last bit. It is the sending end of the team's serial-in/parallel-out receive path and is paced by the same `en` tick convention.

---
 rtl/piso_shift_tx_if.sv | 25 ++
 rtl/piso_shift_tx.sv | 80 ++++++++
 tb/tb_piso_shift_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_tx_if.sv
// Load/serial bundle for the parallel-in/serial-out transmitter.
// master: word source and shift-tick generator (drives load_valid, d, msb_first, en).
// slave:  the transmitter (drives load_ready, sout, busy, done).
interface piso_shift_tx_if #(
    parameter int N = 8
);
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] d;
    logic         msb_first;
    logic         en;
    logic         sout;
    logic         busy;
    logic         done;

    modport master (
        output load_valid, d, msb_first, en,
        input  load_ready, sout, busy, done
    );

    modport slave (
        input  load_valid, d, msb_first, en,
        output load_ready, sout, busy, done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Purpose: parallel-in/serial-out transmitter, MSB- or LSB-first, one bit per en tick.
// Latency: first bit on sout the cycle after accept; done pulses N+1 cycles after accept with en held high.
// Backpressure: load_ready low while shifting; en gaps stretch the current bit.
//
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   syn_clr   - synchronous abort back to idle (no done pulse, no accept that edge)
//   tx.*      - load handshake (load_valid/load_ready, d, msb_first), shift tick en,
//               serial output sout, status busy and done
module piso_shift_tx #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 syn_clr,
    piso_shift_tx_if.slave       tx
);

    localparam int CNT_W = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [N-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            dir    <= 1'b0;
            done_q <= 1'b0;
        end else if (syn_clr) begin
            // dir is left alone: it only matters once a new word is accepted
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx.load_valid) begin
                        shreg <= tx.d;
                        dir   <= tx.msb_first;
                        cnt   <= CNT_W'(N - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tx.en) begin
                        if (cnt == '0) begin
                            state  <= IDLE;
                            shreg  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            // shift toward whichever end feeds sout, zero fill
                            shreg <= dir ? {shreg[N-2:0], 1'b0} : {1'b0, shreg[N-1:1]};
                            cnt   <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so load_ready never depends on load_valid.
    assign tx.load_ready = (state == IDLE);
    assign tx.busy       = (state == SHIFT);
    assign tx.sout       = (state == SHIFT) ? (dir ? shreg[N-1] : shreg[0]) : 1'b0;
    assign tx.done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (N=8): bit order, stalls, back-to-back, abort, async reset.
module tb_piso_shift_tx;

    logic clk;
    logic rst;
    logic syn_clr;

    int n_checks = 0;
    int n_fail   = 0;

    piso_shift_tx_if #(.N(8)) tx_if ();

    piso_shift_tx #(.N(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .syn_clr (syn_clr),
        .tx      (tx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word for exactly one edge (block must be idle), then scramble d/msb_first.
    task automatic accept(input logic [7:0] w, input logic m);
        tx_if.d          = w;
        tx_if.msb_first  = m;
        tx_if.load_valid = 1'b1;
        tick();
        tx_if.load_valid = 1'b0;
        tx_if.d          = ~w;
        tx_if.msb_first  = ~m;
    endtask

    // Collect sout once per cycle (first sample ends up most significant) until done is seen.
    // stall=1 drives en low on odd cycles after the accept, high on even ones.
    // Returns done_cyc = -1 if done never appears within maxc cycles.
    task automatic shift_out(input bit stall, input int maxc,
                             output logic [31:0] samples, output int done_cyc);
        samples  = '0;
        done_cyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            tx_if.en = stall ? ((c % 2) == 0) : 1'b1;
            if (tx_if.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            samples = {samples[30:0], tx_if.sout};
            tick();
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (tx_if.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b expected 1", tx_if.load_ready); end
        n_checks++;
        if (tx_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tx_if.busy); end
        n_checks++;
        if (tx_if.sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b expected 0", tx_if.sout); end
        n_checks++;
        if (tx_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", tx_if.done); end
    endtask

    task automatic test_msb_first();
        logic [31:0] s;
        int dc;
        tx_if.en = 1'b1;
        accept(8'hA5, 1'b1);
        n_checks++;
        if (tx_if.busy !== 1'b1) begin n_fail++; $display("FAIL msb_busy_after_accept: got %b expected 1", tx_if.busy); end
        n_checks++;
        if (tx_if.load_ready !== 1'b0) begin n_fail++; $display("FAIL msb_ready_during_shift: got %b expected 0", tx_if.load_ready); end
        shift_out(1'b0, 20, s, dc);
        n_checks++;
        if (s !== 32'h0000_00A5) begin n_fail++; $display("FAIL msb_stream: got %h expected 000000a5", s); end
        n_checks++;
        if (dc !== 9) begin n_fail++; $display("FAIL msb_done_cycle: got %0d expected 9", dc); end
        n_checks++;
        if (tx_if.load_ready !== 1'b1) begin n_fail++; $display("FAIL msb_ready_in_done_cycle: got %b expected 1", tx_if.load_ready); end
        n_checks++;
        if (tx_if.sout !== 1'b0 || tx_if.busy !== 1'b0) begin n_fail++; $display("FAIL msb_idle_outputs: got sout=%b busy=%b expected 0 0", tx_if.sout, tx_if.busy); end
        tick();
        n_checks++;
        if (tx_if.done !== 1'b0) begin n_fail++; $display("FAIL msb_done_one_cycle: got %b expected 0", tx_if.done); end
    endtask

    task automatic test_lsb_first();
        logic [31:0] s;
        int dc;
        tx_if.en = 1'b1;
        accept(8'hA5, 1'b0);
        shift_out(1'b0, 20, s, dc);
        n_checks++;
        if (s !== 32'h0000_00A5) begin n_fail++; $display("FAIL lsb_a5_stream: got %h expected 000000a5", s); end
        n_checks++;
        if (dc !== 9) begin n_fail++; $display("FAIL lsb_a5_done_cycle: got %0d expected 9", dc); end
        tick();
        accept(8'h01, 1'b0);
        shift_out(1'b0, 20, s, dc);
        n_checks++;
        if (s !== 32'h0000_0080) begin n_fail++; $display("FAIL lsb_01_stream: got %h expected 00000080", s); end
        n_checks++;
        if (dc !== 9) begin n_fail++; $display("FAIL lsb_01_done_cycle: got %0d expected 9", dc); end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] s;
        int dc;
        accept(8'hF0, 1'b1);
        shift_out(1'b1, 40, s, dc);
        // every bit held for two cycles: 11110000 doubled
        n_checks++;
        if (s !== 32'h0000_FF00) begin n_fail++; $display("FAIL stall_stream: got %h expected 0000ff00", s); end
        n_checks++;
        if (dc !== 17) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 17", dc); end
        tx_if.en = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [17:0] s;
        logic [17:0] dmask;
        logic [17:0] rmask;
        s = '0; dmask = '0; rmask = '0;
        tx_if.en         = 1'b1;
        tx_if.d          = 8'h81;
        tx_if.msb_first  = 1'b1;
        tx_if.load_valid = 1'b1;
        tick();
        tx_if.d = 8'h7E;   // next word, also shows d is ignored mid-shift
        for (int c = 1; c <= 18; c++) begin
            if (c == 10) begin
                tx_if.load_valid = 1'b0;
                tx_if.d          = 8'hFF;
                tx_if.msb_first  = 1'b0;
            end
            s     = {s[16:0], tx_if.sout};
            dmask = {dmask[16:0], tx_if.done};
            rmask = {rmask[16:0], tx_if.load_ready};
            tick();
        end
        n_checks++;
        if (s !== 18'b10000001_0_01111110_0) begin n_fail++; $display("FAIL b2b_stream: got %b expected 100000010011111100", s); end
        n_checks++;
        if (dmask !== 18'b000000001_000000001) begin n_fail++; $display("FAIL b2b_done_cycles: got %b expected 000000001000000001", dmask); end
        n_checks++;
        if (rmask !== 18'b000000001_000000001) begin n_fail++; $display("FAIL b2b_ready_cycles: got %b expected 000000001000000001", rmask); end
        n_checks++;
        if (tx_if.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b expected 0", tx_if.busy); end
    endtask

    task automatic test_abort();
        int dcount;
        tx_if.en = 1'b1;
        accept(8'hA5, 1'b1);
        tick(); tick(); tick();   // three bits consumed, fourth bit (0) on sout
        n_checks++;
        if (tx_if.busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", tx_if.busy); end
        syn_clr = 1'b1;
        tick();
        syn_clr = 1'b0;
        n_checks++;
        if (tx_if.busy !== 1'b0 || tx_if.load_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got busy=%b ready=%b expected 0 1", tx_if.busy, tx_if.load_ready); end
        n_checks++;
        if (tx_if.sout !== 1'b0) begin n_fail++; $display("FAIL abort_sout: got %b expected 0", tx_if.sout); end
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            if (tx_if.done === 1'b1) dcount++;
            tick();
        end
        n_checks++;
        if (dcount !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", dcount); end
        tx_if.d          = 8'hFF;
        tx_if.msb_first  = 1'b1;
        tx_if.load_valid = 1'b1;
        syn_clr          = 1'b1;
        tick();
        tx_if.load_valid = 1'b0;
        syn_clr          = 1'b0;
        n_checks++;
        if (tx_if.busy !== 1'b0 || tx_if.sout !== 1'b0) begin n_fail++; $display("FAIL abort_no_accept: got busy=%b sout=%b expected 0 0", tx_if.busy, tx_if.sout); end
    endtask

    task automatic test_async_reset();
        logic [31:0] s;
        int dc;
        tx_if.en = 1'b1;
        accept(8'hFF, 1'b1);
        tick(); tick();
        n_checks++;
        if (tx_if.busy !== 1'b1 || tx_if.sout !== 1'b1) begin n_fail++; $display("FAIL arst_midword: got busy=%b sout=%b expected 1 1", tx_if.busy, tx_if.sout); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (tx_if.load_ready !== 1'b1 || tx_if.busy !== 1'b0) begin n_fail++; $display("FAIL arst_immediate_ctrl: got ready=%b busy=%b expected 1 0", tx_if.load_ready, tx_if.busy); end
        n_checks++;
        if (tx_if.sout !== 1'b0 || tx_if.done !== 1'b0) begin n_fail++; $display("FAIL arst_immediate_data: got sout=%b done=%b expected 0 0", tx_if.sout, tx_if.done); end
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        n_checks++;
        if (tx_if.done !== 1'b0 || tx_if.busy !== 1'b0) begin n_fail++; $display("FAIL arst_release: got done=%b busy=%b expected 0 0", tx_if.done, tx_if.busy); end
        accept(8'h3C, 1'b0);
        shift_out(1'b0, 20, s, dc);
        n_checks++;
        if (s !== 32'h0000_003C) begin n_fail++; $display("FAIL arst_fresh_stream: got %h expected 0000003c", s); end
        n_checks++;
        if (dc !== 9) begin n_fail++; $display("FAIL arst_fresh_done_cycle: got %0d expected 9", dc); end
        tick();
    endtask

    initial begin
        rst              = 1'b1;
        syn_clr          = 1'b0;
        tx_if.load_valid = 1'b0;
        tx_if.d          = '0;
        tx_if.msb_first  = 1'b0;
        tx_if.en         = 1'b0;
        #1;
        test_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
